bool_equiv_sweep: RTL and testbench

Sequential equivalence checker for two N-input Boolean expressions. On `start` it sweeps every input vector 0 .. 2^N-1 onto `vec`, one per clock. Each cycle it compares the two expression results that the surrounding combinational modules return for that vector, and it accumulates the mismatch count and the first failing vector. It generalises the fixed two-variable truth-table comparison to N variables, with don't-care masking and an early-stop mode. It sits between a stimulus/expression pair and the test harness.

---
 rtl/bool_equiv_sweep_if.sv | 27 ++
 rtl/bool_equiv_sweep.sv | 79 +++++++
 tb/tb_bool_equiv_sweep.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bool_equiv_sweep_if.sv
// Handshake and vector bus between the sweep checker and the stimulus/expression harness.
interface bool_equiv_sweep_if #(
    parameter int N = 2
);
    logic         start;
    logic         stop_on_fail;
    logic         f_a;
    logic         f_b;
    logic         dc;
    logic [N-1:0] vec;
    logic         busy;
    logic         done;
    logic         equal;
    logic [N:0]   mismatch_cnt;
    logic [N-1:0] first_bad;
    logic         first_valid;

    modport master (
        output start, stop_on_fail, f_a, f_b, dc,
        input  vec, busy, done, equal, mismatch_cnt, first_bad, first_valid
    );

    modport slave (
        input  start, stop_on_fail, f_a, f_b, dc,
        output vec, busy, done, equal, mismatch_cnt, first_bad, first_valid
    );
endinterface

// File: rtl/bool_equiv_sweep.sv
// Exhaustive sequential equivalence sweep of two N-input Boolean expressions,
// with don't-care masking, mismatch counting and optional stop at first failure.
module bool_equiv_sweep #(
    parameter int N = 2
) (
    input logic               clk,
    input logic               rst_n,
    bool_equiv_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] vec_q;
    logic [N:0]   cnt_q;
    logic [N-1:0] first_bad_q;
    logic         first_valid_q;
    logic         stop_q;
    logic         clear;
    logic         mismatch;
    logic         last_vec;

    assign mismatch = (state_q == SWEEP) && (bus.f_a != bus.f_b) && !bus.dc;
    assign last_vec = (vec_q == {N{1'b1}});

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = SWEEP;
                    clear   = 1'b1;
                end
            end
            SWEEP: begin
                // Terminal vector ends the sweep here, so vec never wraps
                if (last_vec || (stop_q && mismatch)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            cnt_q         <= '0;
            first_bad_q   <= '0;
            first_valid_q <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                vec_q         <= '0;
                cnt_q         <= '0;
                first_bad_q   <= '0;
                first_valid_q <= 1'b0;
                stop_q        <= bus.stop_on_fail;
            end else if (state_q == SWEEP) begin
                if (mismatch) begin
                    cnt_q <= cnt_q + (N+1)'(1);
                    if (!first_valid_q) begin
                        first_bad_q   <= vec_q;
                        first_valid_q <= 1'b1;
                    end
                end
                if (state_d == SWEEP) vec_q <= vec_q + N'(1);
            end
        end
    end

    assign bus.vec          = vec_q;
    assign bus.busy         = (state_q == SWEEP);
    assign bus.done         = (state_q == DONE);
    assign bus.equal        = (state_q == DONE) && (cnt_q == '0);
    assign bus.mismatch_cnt = cnt_q;
    assign bus.first_bad    = first_bad_q;
    assign bus.first_valid  = first_valid_q;
endmodule

// File: tb/tb_bool_equiv_sweep.sv
// Directed bench for bool_equiv_sweep: an N=2 and an N=3 instance driven by small expression models.
module tb_bool_equiv_sweep;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode2 = 0;
    int   mode3 = 0;
    int   vlog[8];
    int   nlog;
    int   edges;

    bool_equiv_sweep_if #(.N(2)) bus2 ();
    bool_equiv_sweep_if #(.N(3)) bus3 ();

    bool_equiv_sweep #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    bool_equiv_sweep #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    // N=2: mode 0 is the equivalent pair, otherwise every vector fails
    always_comb begin
        bus2.f_a = 1'b0;
        bus2.f_b = 1'b0;
        bus2.dc  = 1'b0;
        if (mode2 == 0) begin
            bus2.f_a = ~bus2.vec[1] & bus2.vec[0];
            bus2.f_b = ~bus2.vec[1] & ~(bus2.vec[1] | ~bus2.vec[0]);
        end else begin
            bus2.f_a = bus2.vec[0];
            bus2.f_b = ~bus2.vec[0];
        end
    end

    // N=3: 0 fault at 5, 1 faults at 2 and 6, 2 fault at 5 masked, 3 equivalent
    always_comb begin
        bus3.f_a = ^bus3.vec;
        bus3.f_b = ^bus3.vec;
        bus3.dc  = 1'b0;
        case (mode3)
            0: bus3.f_b = (^bus3.vec) ^ (bus3.vec == 3'd5);
            1: bus3.f_b = (^bus3.vec) ^ ((bus3.vec == 3'd2) || (bus3.vec == 3'd6));
            2: begin
                bus3.f_b = (^bus3.vec) ^ (bus3.vec == 3'd5);
                bus3.dc  = (bus3.vec == 3'd5);
            end
            default: bus3.f_b = ^bus3.vec;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns edges counted from the start edge to done
    task automatic run2(output int n_edges);
        bus2.stop_on_fail = 1'b0;
        bus2.start        = 1'b1;
        @(posedge clk);
        n_edges = 1;
        nlog    = 0;
        @(negedge clk);
        bus2.start = 1'b0;
        while (!bus2.done && n_edges < 64) begin
            if (bus2.busy && nlog < 8) begin
                vlog[nlog] = int'(bus2.vec);
                nlog++;
            end
            @(posedge clk);
            n_edges++;
            @(negedge clk);
        end
        chk("done2", bus2.done, 1);
        chk("busy2_off", bus2.busy, 0);
    endtask

    task automatic run3(input bit sof, input bit hold, output int n_edges);
        bus3.stop_on_fail = sof;
        bus3.start        = 1'b1;
        @(posedge clk);
        n_edges = 1;
        @(negedge clk);
        if (!hold) bus3.start = 1'b0;
        bus3.stop_on_fail = ~sof;
        chk("start_busy", bus3.busy, 1);
        chk("start_done", bus3.done, 0);
        chk("start_vec", bus3.vec, 0);
        chk("start_cnt", bus3.mismatch_cnt, 0);
        chk("start_fv", bus3.first_valid, 0);
        while (!bus3.done && n_edges < 64) begin
            chk("eq_busy", bus3.equal & bus3.busy, 0);
            @(posedge clk);
            n_edges++;
            @(negedge clk);
        end
        bus3.start = 1'b0;
        chk("done3", bus3.done, 1);
        chk("busy3_off", bus3.busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus2.start = 1'b0; bus2.stop_on_fail = 1'b0;
        bus3.start = 1'b0; bus3.stop_on_fail = 1'b0;
        @(negedge clk);
        chk("rst_vec", bus3.vec, 0);
        chk("rst_busy", bus3.busy, 0);
        chk("rst_done", bus3.done, 0);
        chk("rst_equal", bus3.equal, 0);
        chk("rst_cnt", bus3.mismatch_cnt, 0);
        chk("rst_fb", bus3.first_bad, 0);
        chk("rst_fv", bus3.first_valid, 0);
        chk("rst_done2", bus2.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Equivalent pair, N=2
        mode2 = 0;
        run2(edges);
        chk("eq2_edges", edges, 5);
        chk("eq2_nlog", nlog, 4);
        for (int i = 0; i < 4; i++) chk("eq2_vec_step", vlog[i], i);
        chk("eq2_equal", bus2.equal, 1);
        chk("eq2_cnt", bus2.mismatch_cnt, 0);
        chk("eq2_fv", bus2.first_valid, 0);
        chk("eq2_vec_hold", bus2.vec, 3);

        // All vectors fail, N=2
        mode2 = 1;
        run2(edges);
        chk("all2_edges", edges, 5);
        chk("all2_cnt", bus2.mismatch_cnt, 4);
        chk("all2_fb", bus2.first_bad, 0);
        chk("all2_fv", bus2.first_valid, 1);
        chk("all2_equal", bus2.equal, 0);

        // Single fault at 5, N=3
        mode3 = 0;
        run3(1'b0, 1'b0, edges);
        chk("sf_edges", edges, 9);
        chk("sf_cnt", bus3.mismatch_cnt, 1);
        chk("sf_fb", bus3.first_bad, 5);
        chk("sf_fv", bus3.first_valid, 1);
        chk("sf_equal", bus3.equal, 0);
        chk("sf_vec", bus3.vec, 7);

        // Early stop at vector 2
        mode3 = 1;
        run3(1'b1, 1'b0, edges);
        chk("es_edges", edges, 4);
        chk("es_vec", bus3.vec, 2);
        chk("es_cnt", bus3.mismatch_cnt, 1);
        chk("es_fb", bus3.first_bad, 2);
        chk("es_equal", bus3.equal, 0);

        // Same faults without stop: both counted, first stays 2
        run3(1'b0, 1'b0, edges);
        chk("ns_edges", edges, 9);
        chk("ns_cnt", bus3.mismatch_cnt, 2);
        chk("ns_fb", bus3.first_bad, 2);

        // Fault at 5 masked by dc
        mode3 = 2;
        run3(1'b0, 1'b0, edges);
        chk("dc_edges", edges, 9);
        chk("dc_equal", bus3.equal, 1);
        chk("dc_cnt", bus3.mismatch_cnt, 0);
        chk("dc_fv", bus3.first_valid, 0);

        // Reset in the middle of a sweep, between clock edges
        mode3 = 0;
        bus3.stop_on_fail = 1'b0;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        for (int k = 0; k < 20 && bus3.vec != 3'd3; k++) @(negedge clk);
        chk("mid_vec", bus3.vec, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vec", bus3.vec, 0);
        chk("ar_busy", bus3.busy, 0);
        chk("ar_done", bus3.done, 0);
        chk("ar_equal", bus3.equal, 0);
        chk("ar_cnt", bus3.mismatch_cnt, 0);
        chk("ar_fb", bus3.first_bad, 0);
        chk("ar_fv", bus3.first_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode3 = 3;
        run3(1'b0, 1'b0, edges);
        chk("pr_edges", edges, 9);
        chk("pr_equal", bus3.equal, 1);
        chk("pr_cnt", bus3.mismatch_cnt, 0);

        // start held high through a sweep, then a restart from DONE
        mode3 = 0;
        run3(1'b0, 1'b1, edges);
        chk("hold_edges", edges, 9);
        chk("hold_cnt", bus3.mismatch_cnt, 1);
        chk("hold_fb", bus3.first_bad, 5);
        run3(1'b0, 1'b0, edges);
        chk("re_edges", edges, 9);
        chk("re_cnt", bus3.mismatch_cnt, 1);
        chk("re_fb", bus3.first_bad, 5);
        chk("re_fv", bus3.first_valid, 1);
        chk("re_equal", bus3.equal, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
